// File: rtl/row_unpacker_if.sv
// Memory write port of the row unpacker: registered write request plus the
// memory's ready/accept handshake.
interface row_unpacker_if #(
  parameter int ADDR_W = 8
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_value;
  logic [15:0]       mem_index;
  logic              mem_ready;

  modport master (
    output mem_we, mem_addr, mem_value, mem_index,
    input  mem_ready
  );

  modport slave (
    input  mem_we, mem_addr, mem_value, mem_index,
    output mem_ready
  );
endinterface

// File: rtl/row_unpacker.sv
// Unpacks one received sparse matrix row (count, values, indices) into a
// sequence of single-entry memory writes at consecutive addresses.
//
// state | meaning
// IDLE  | waiting for a packed row on in_valid
// CHECK | validating the latched entry count
// WRITE | presenting entry k to memory until accepted
// DONE  | one-cycle done pulse, row finished
// ERR   | one-cycle error pulse, row rejected without writes
module row_unpacker #(
  parameter int MATRIX_N = 4,
  parameter int HEADER   = 1,
  parameter int ADDR_W   = 8,
  localparam int DW      = HEADER*8 + 32*MATRIX_N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  input  logic [ADDR_W-1:0] row_base,
  row_unpacker_if.master    mem,
  output logic              done,
  output logic              error,
  output logic              overrun,
  output logic              busy,
  output logic [15:0]       total_entries
);

  localparam int CW = HEADER*8;
  localparam int KW = (MATRIX_N > 1) ? $clog2(MATRIX_N) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t            state;
  logic [DW-1:0]     row_q;
  logic [ADDR_W-1:0] base_q;
  logic [KW-1:0]     k_q;
  logic [KW-1:0]     k_nxt;
  logic [CW-1:0]     count_q;
  logic              last_entry;
  logic [15:0]       val_slot [MATRIX_N];
  logic [15:0]       idx_slot [MATRIX_N];

  // Slot 0 sits at the top of each field, i.e. the first entry received.
  for (genvar i = 0; i < MATRIX_N; i++) begin : g_slot
    assign val_slot[i] = row_q[32*MATRIX_N-1-16*i -: 16];
    assign idx_slot[i] = row_q[16*MATRIX_N-1-16*i -: 16];
  end

  assign count_q    = row_q[DW-1 -: CW];
  assign k_nxt      = k_q + KW'(1);
  assign last_entry = (CW'(k_q) == (count_q - CW'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      row_q         <= '0;
      base_q        <= '0;
      k_q           <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_value <= '0;
      mem.mem_index <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
      total_entries <= '0;
    end else begin
      done    <= 1'b0;
      error   <= 1'b0;
      // A row arriving while any earlier row is still in flight is dropped.
      overrun <= in_valid && (state != IDLE);

      case (state)
        IDLE: begin
          if (in_valid) begin
            row_q  <= in_data;
            base_q <= row_base;
            state  <= CHECK;
            busy   <= 1'b1;
          end
        end

        CHECK: begin
          if ((count_q == '0) || (count_q > CW'(MATRIX_N))) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            state         <= WRITE;
            k_q           <= '0;
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= base_q;
            mem.mem_value <= val_slot[0];
            mem.mem_index <= idx_slot[0];
          end
        end

        WRITE: begin
          if (mem.mem_ready) begin
            if (total_entries != 16'hFFFF) begin
              total_entries <= total_entries + 16'd1;
            end
            if (last_entry) begin
              mem.mem_we <= 1'b0;
              state      <= DONE;
              done       <= 1'b1;
            end else begin
              k_q           <= k_nxt;
              mem.mem_addr  <= base_q + ADDR_W'(k_nxt);
              mem.mem_value <= val_slot[k_nxt];
              mem.mem_index <= idx_slot[k_nxt];
            end
          end
        end

        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          mem.mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/row_unpacker.md
ROW_UNPACKER -- requirements
Module: row_unpacker

Interface
REQ-001 SHALL have parameter MATRIX_N, default 4, meaning entries per matrix row/col.
REQ-002 SHALL have parameter HEADER, default 1, meaning header bytes carrying the entry count.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning memory address width.
REQ-004 SHALL define DW = HEADER*8 + 32*MATRIX_N as the packed-row width.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, one-cycle pulse meaning in_data holds a complete packed row (driven by comm controller rx_complete).
REQ-008 SHALL have port in_data, input, DW, packed row: count, values, indices.
REQ-009 SHALL have port row_base, input, ADDR_W, first memory address for this row.
REQ-010 SHALL have port mem_ready, input, 1, memory accepts the presented write this cycle.
REQ-011 SHALL have port mem_we, output, 1, write request.
REQ-012 SHALL have port mem_addr, output, ADDR_W, write address.
REQ-013 SHALL have port mem_value, output, 16, entry value.
REQ-014 SHALL have port mem_index, output, 16, entry column/row index.
REQ-015 SHALL have port done, output, 1, one-cycle pulse after the last entry of a row is accepted.
REQ-016 SHALL have port error, output, 1, one-cycle pulse on a rejected row.
REQ-017 SHALL have port overrun, output, 1, one-cycle pulse when in_valid arrives while busy.
REQ-018 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-019 SHALL have port total_entries, output, 16, count of entries written since reset.

Function
REQ-020 SHALL decode in_data: count = in_data[DW-1 -: HEADER*8]; value slot k = in_data[32*MATRIX_N-1-16k -: 16]; index slot k = in_data[16*MATRIX_N-1-16k -: 16]; slot 0 = first received.
REQ-021 SHALL implement states IDLE, CHECK, WRITE, DONE, ERR.
REQ-022 IDLE: on in_valid=1 SHALL register in_data and row_base at that edge and enter CHECK; otherwise remain.
REQ-023 CHECK: count==0 or count>MATRIX_N -> ERR; else -> WRITE with entry counter k=0.
REQ-024 WRITE: SHALL drive mem_we=1, mem_addr=base+k (mod 2^ADDR_W), mem_value/mem_index = slot k, all registered and stable until accepted.
REQ-025 An entry SHALL be accepted at a rising edge where mem_we=1 and mem_ready=1; k increments by 1 on acceptance only.
REQ-026 On acceptance with k==count-1 SHALL deassert mem_we and enter DONE; otherwise present entry k+1 next cycle with mem_we held high.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; ERR: error=1 for exactly one cycle, no writes, then IDLE.
REQ-028 Minimum latency: in_valid to first mem_we = 2 cycles; with mem_ready held high, one entry per cycle.
REQ-029 in_valid in any non-IDLE state SHALL be ignored (latched row unchanged) and SHALL pulse overrun the following cycle.
REQ-030 in_valid in the cycle DONE/ERR returns to IDLE counts as busy (overrun), not accepted.
REQ-031 total_entries SHALL increment on every acceptance and saturate at 0xFFFF.
REQ-032 mem_value/mem_index/mem_addr SHALL be don't-care-stable (hold last value) when mem_we=0.

Reset
REQ-033 Asserting reset at any time, including mid-WRITE, SHALL immediately force IDLE and clear mem_we, mem_addr, mem_value, mem_index, done, error, overrun, busy, total_entries and k to 0; partial rows are discarded.
REQ-034 After reset deassertion, first in_valid SHALL be accepted normally.

Verification
REQ-035 count=2, values 0x0011,0x0022, indices 0x0001,0x0003, row_base=0x10, mem_ready=1 -> writes (0x10,0x0011,0x0001),(0x11,0x0022,0x0003), done pulse, total_entries=2.
REQ-036 Same row, mem_ready low 3 cycles on entry 0 -> mem_we and entry 0 held stable 4 cycles, no duplicate or skipped writes.
REQ-037 count=0 and count=5 (MATRIX_N=4) -> error pulse, mem_we never asserted, total_entries unchanged.
REQ-038 row_base=0xFF, count=4 -> addresses 0xFF,0x00,0x01,0x02.
REQ-039 second in_valid during WRITE -> overrun pulse next cycle, first row completes unaltered.
REQ-040 reset asserted after entry 1 of 4 accepted -> all outputs 0 asynchronously, next row starts at k=0.
